// File: rtl/tms1x00_pkg.sv
// Shared types and SRAM geometry for the TMS1x00 program store.
// Used by the Wishbone-to-SRAM bridge and its bench.
package tms1x00_pkg;

  localparam int SRAM_WORDS     = 512;
  localparam int SRAM_ADDR_BITS = 9;
  localparam int SRAM_DATA_BITS = 32;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

endpackage

// File: rtl/wb_sram_bridge_if.sv
// Wishbone classic bundle between the user-area bus
// and the program-store bridge.
interface wb_sram_bridge_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave owning port 0 of the program SRAM.
// All SRAM pins are registered; read latency folded into one ack.
module wb_sram_bridge
  import tms1x00_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          ADDR_BITS = SRAM_ADDR_BITS,
  parameter int          READ_LAT  = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_sram_bridge_if.slave      wb,
  input  logic                 wp_i,
  output logic                 sram_csb_o,
  output logic                 sram_web_o,
  output logic [ADDR_BITS-1:0] sram_addr_o,
  output logic [3:0]           sram_wmask_o,
  output logic [31:0]          sram_din_o,
  input  logic [31:0]          sram_dout_i
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  abort_q, abort_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;
  logic [31:0]           din_q, din_d;

  logic hit, req, abort;
  logic unused_ok;

  assign unused_ok = ^{wb.wbs_adr_i[1:0]};

  assign hit   = wb.wbs_adr_i[31:11] == BASE_ADDR[31:11];
  assign req   = wb.wbs_cyc_i & wb.wbs_stb_i & hit;
  assign abort = abort_q | ~wb.wbs_cyc_i;

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = csb_q;
    web_d   = web_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          addr_d  = wb.wbs_adr_i[ADDR_BITS+1:2];
          mask_d  = wb.wbs_sel_i;
          din_d   = wb.wbs_dat_i;
          web_d   = ~wb.wbs_we_i;
          csb_d   = wb.wbs_we_i & wp_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        abort_d = abort;
        if (!web_q) begin
          if (abort) begin
            state_d = IDLE;
          end else begin
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end else begin
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        abort_d = abort;
        if (cnt_q == 2'd0) begin
          if (abort) begin
            state_d = IDLE;
          end else begin
            dat_d   = sram_dout_i;
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      mask_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      din_q   <= din_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign sram_csb_o   = csb_q;
  assign sram_web_o   = web_q;
  assign sram_addr_o  = addr_q;
  assign sram_wmask_o = mask_q;
  assign sram_din_o   = din_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for the program-store bridge.
// Two instances: READ_LAT=1 and READ_LAT=3, each with an SRAM model.
module tb_wb_sram_bridge;
  import tms1x00_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_sram_bridge_if if1 ();
  wb_sram_bridge_if if3 ();

  logic        which;
  logic        cyc, stb, we, wp;
  logic [3:0]  sel;
  logic [31:0] adr, dat;

  logic        csb1, web1, csb3, web3;
  logic [8:0]  addr1, addr3;
  logic [3:0]  mask1, mask3;
  logic [31:0] din1, din3, dout1, dout3;

  assign if1.wbs_cyc_i = cyc & ~which;
  assign if1.wbs_stb_i = stb & ~which;
  assign if1.wbs_we_i  = we;
  assign if1.wbs_sel_i = sel;
  assign if1.wbs_adr_i = adr;
  assign if1.wbs_dat_i = dat;
  assign if3.wbs_cyc_i = cyc & which;
  assign if3.wbs_stb_i = stb & which;
  assign if3.wbs_we_i  = we;
  assign if3.wbs_sel_i = sel;
  assign if3.wbs_adr_i = adr;
  assign if3.wbs_dat_i = dat;

  wb_sram_bridge #(.READ_LAT(1)) u_dut1 (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb           (if1.slave),
    .wp_i         (wp),
    .sram_csb_o   (csb1),
    .sram_web_o   (web1),
    .sram_addr_o  (addr1),
    .sram_wmask_o (mask1),
    .sram_din_o   (din1),
    .sram_dout_i  (dout1)
  );

  wb_sram_bridge #(.READ_LAT(3)) u_dut3 (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb           (if3.slave),
    .wp_i         (wp),
    .sram_csb_o   (csb3),
    .sram_web_o   (web3),
    .sram_addr_o  (addr3),
    .sram_wmask_o (mask3),
    .sram_din_o   (din3),
    .sram_dout_i  (dout3)
  );

  logic [31:0] mem1 [SRAM_WORDS];
  logic [31:0] mem3 [SRAM_WORDS];
  logic [31:0] r1, r3a, r3b, r3c;

  assign dout1 = r1;
  assign dout3 = r3c;

  // SRAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (!csb1) begin
      if (!web1) begin
        for (int b = 0; b < 4; b++)
          if (mask1[b]) mem1[addr1][8*b +: 8] <= din1[8*b +: 8];
      end else begin
        r1 <= mem1[addr1];
      end
    end
  end

  // SRAM model, three-cycle read latency.
  always @(posedge clk) begin
    r3b <= r3a;
    r3c <= r3b;
    if (!csb3) begin
      if (!web3) begin
        for (int b = 0; b < 4; b++)
          if (mask3[b]) mem3[addr3][8*b +: 8] <= din3[8*b +: 8];
      end else begin
        r3a <= mem3[addr3];
      end
    end
  end

  logic        o_ack, o_csb, o_web;
  logic [31:0] o_dat, o_din;
  logic [8:0]  o_addr;
  logic [3:0]  o_mask;

  always_comb begin
    o_ack  = which ? if3.wbs_ack_o : if1.wbs_ack_o;
    o_dat  = which ? if3.wbs_dat_o : if1.wbs_dat_o;
    o_csb  = which ? csb3 : csb1;
    o_web  = which ? web3 : web1;
    o_addr = which ? addr3 : addr1;
    o_mask = which ? mask3 : mask1;
    o_din  = which ? din3 : din1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  int          ack_cyc, csb_n, st3;
  logic [31:0] rdat, c_din;
  logic [8:0]  c_addr;
  logic [3:0]  c_mask;
  logic        c_web;

  // One request from cycle 0; observes 12 cycles at negedge.
  task automatic xfer(input logic        we_v,
                      input logic [31:0] adr_v,
                      input logic [31:0] dat_v,
                      input logic [3:0]  sel_v,
                      input logic        wp_v,
                      input logic        drop);
    ack_cyc = -1;
    csb_n   = 0;
    st3     = -1;
    rdat    = '0;
    c_addr  = '0;
    c_mask  = '0;
    c_din   = '0;
    c_web   = 1'b1;
    we  = we_v;
    adr = adr_v;
    dat = dat_v;
    sel = sel_v;
    wp  = wp_v;
    cyc = 1'b1;
    stb = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) st3 = int'(u_dut1.state_q);
      if (!o_csb) begin
        csb_n++;
        c_addr = o_addr;
        c_mask = o_mask;
        c_din  = o_din;
        c_web  = o_web;
      end
      if (o_ack && ack_cyc < 0) begin
        ack_cyc = k;
        rdat    = o_dat;
      end
      if (o_ack || (drop && k == 1)) begin
        cyc = 1'b0;
        stb = 1'b0;
      end
    end
    cyc = 1'b0;
    stb = 1'b0;
    wp  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SRAM_WORDS; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    which = 1'b0;
    rst = 1'b1;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    wp  = 1'b0;
    sel = '0;
    adr = '0;
    dat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, o_ack}, 32'd0);
    check("rst_dat", o_dat, 32'd0);
    check("rst_csb_web", {30'd0, o_csb, o_web}, 32'd3);
    check("rst_addr_mask", {19'd0, o_addr, o_mask}, 32'd0);
    check("rst_din", o_din, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    check("wr_ack_cyc", ack_cyc, 32'd2);
    check("wr_csb_cnt", csb_n, 32'd1);
    check("wr_web", {31'd0, c_web}, 32'd0);
    check("wr_addr", {23'd0, c_addr}, 32'd4);
    check("wr_mask", {28'd0, c_mask}, 32'hF);
    check("wr_din", c_din, 32'hDEAD_BEEF);
    check("wr_mem", mem1[4], 32'hDEAD_BEEF);

    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b0);
    check("rd1_ack_cyc", ack_cyc, 32'd3);
    check("rd1_dat", rdat, 32'hDEAD_BEEF);
    check("rd1_web", {31'd0, c_web}, 32'd1);

    which = 1'b1;
    xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    check("wr3_ack_cyc", ack_cyc, 32'd2);
    xfer(1'b0, 32'h3000_0012, 32'h0, 4'hF, 1'b0, 1'b0);
    check("rd3_ack_cyc", ack_cyc, 32'd5);
    check("rd3_dat", rdat, 32'hDEAD_BEEF);
    which = 1'b0;

    xfer(1'b1, 32'h3000_07FC, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    check("top_addr", {23'd0, c_addr}, 32'd511);
    xfer(1'b1, 32'h3000_07FC, 32'hAAAA_5555, 4'hF, 1'b1, 1'b0);
    check("wp_csb_cnt", csb_n, 32'd0);
    check("wp_ack_cyc", ack_cyc, 32'd2);
    xfer(1'b0, 32'h3000_07FC, 32'h0, 4'hF, 1'b0, 1'b0);
    check("wp_rd_ack", ack_cyc, 32'd3);
    check("wp_rd_dat", rdat, 32'h1234_5678);

    xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF, 1'b0, 1'b0);
    check("miss1_ack", ack_cyc, 32'hFFFF_FFFF);
    check("miss1_csb", csb_n, 32'd0);
    xfer(1'b1, 32'h2000_0000, 32'h5A5A_5A5A, 4'hF, 1'b0, 1'b0);
    check("miss2_ack", ack_cyc, 32'hFFFF_FFFF);
    check("miss2_csb", csb_n, 32'd0);

    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b1);
    check("abort_csb", csb_n, 32'd1);
    check("abort_ack", ack_cyc, 32'hFFFF_FFFF);
    check("abort_dat", o_dat, 32'h1234_5678);
    check("abort_idle", st3, 32'd0);

    xfer(1'b1, 32'h3000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    check("sel0_csb", csb_n, 32'd1);
    check("sel0_mask", {28'd0, c_mask}, 32'd0);
    check("sel0_ack", ack_cyc, 32'd2);
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b0);
    check("sel0_rd", rdat, 32'hDEAD_BEEF);

    which = 1'b1;
    we  = 1'b0;
    adr = 32'h3000_0010;
    sel = 4'hF;
    cyc = 1'b1;
    stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_ack", {31'd0, o_ack}, 32'd0);
    check("mrst_csb", {31'd0, o_csb}, 32'd1);
    check("mrst_dat", o_dat, 32'd0);
    rst = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (o_ack) check("mrst_lost_ack", {31'd0, o_ack}, 32'd0);
    end
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b0);
    check("post_rst_ack", ack_cyc, 32'd5);
    check("post_rst_dat", rdat, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
